// File: rtl/image_scanner.sv
// image_scanner: raster-scans an img_width x img_height image memory and streams
// the pixels over a valid/ready interface, one pixel every two cycles when unstalled.
// Optional feature: define FRAME_CHECKSUM_EN to add a 16-bit per-frame pixel sum output.
module image_scanner #(
  parameter int img_height = 4,
  parameter int img_width  = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  output logic [3:0] x,
  output logic [3:0] y,
  input  logic [7:0] pixel_in,
  input  logic       pixel_in_valid,
  output logic [7:0] pix_data,
  output logic       pix_valid,
  input  logic       pix_ready,
  output logic       pix_eol,
  output logic       pix_eof,
  output logic       busy,
  output logic       done
`ifdef FRAME_CHECKSUM_EN
  ,
  output logic [15:0] checksum
`endif
);

  localparam logic [3:0] X_LAST = 4'(img_width - 1);
  localparam logic [3:0] Y_LAST = 4'(img_height - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    HOLD  = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t state, state_next;

  logic at_last_col;
  logic at_last_row;
  logic handshake;

  assign at_last_col = (x == X_LAST);
  assign at_last_row = (y == Y_LAST);
  assign handshake   = (state == HOLD) && pix_valid && pix_ready;

  // State register
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // Next-state logic: FETCH waits for the memory, HOLD waits for the consumer
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = FETCH;
      FETCH:   if (pixel_in_valid) state_next = HOLD;
      HOLD:    if (handshake) state_next = (at_last_col && at_last_row) ? DONE : FETCH;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Status outputs decoded from the state
  always_comb begin
    busy = (state != IDLE);
    done = (state == DONE);
  end

  // Scan address and output pixel register; everything holds while stalled in HOLD
  always_ff @(posedge clk) begin
    if (reset) begin
      x         <= '0;
      y         <= '0;
      pix_data  <= '0;
      pix_valid <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            x <= '0;
            y <= '0;
          end
        end
        FETCH: begin
          if (pixel_in_valid) begin
            pix_data  <= pixel_in;
            pix_valid <= 1'b1;
          end
        end
        HOLD: begin
          if (handshake) begin
            pix_valid <= 1'b0;
            // Last pixel leaves the address parked; the next start reloads it
            if (!(at_last_col && at_last_row)) begin
              if (at_last_col) begin
                x <= '0;
                y <= y + 4'd1;
              end else begin
                x <= x + 4'd1;
              end
            end
          end
        end
        default: ;
      endcase
    end
  end

  // Row/frame markers follow the held address, so they stay stable through a stall
  always_comb begin
    pix_eol = pix_valid && at_last_col;
    pix_eof = pix_valid && at_last_col && at_last_row;
  end

`ifdef FRAME_CHECKSUM_EN
  // Frame sum: cleared when a scan is accepted, accumulates each delivered pixel
  always_ff @(posedge clk) begin
    if (reset)                       checksum <= '0;
    else if (state == IDLE && start) checksum <= '0;
    else if (handshake)              checksum <= checksum + {8'd0, pix_data};
  end
`endif

endmodule

// File: tb/tb_image_scanner.sv
// Directed bench for image_scanner: clean frame, consumer stall, memory bubble,
// start during HOLD, and mid-frame reset followed by a replayed frame.
module tb_image_scanner;

  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic [3:0] x;
  logic [3:0] y;
  logic [7:0] pixel_in;
  logic       pixel_in_valid;
  logic [7:0] pix_data;
  logic       pix_valid;
  logic       pix_ready;
  logic       pix_eol;
  logic       pix_eof;
  logic       busy;
  logic       done;
`ifdef FRAME_CHECKSUM_EN
  logic [15:0] checksum;
`endif

  logic [7:0] mem [16];

  int checks = 0;
  int errors = 0;

  image_scanner #(.img_height(4), .img_width(4)) dut (
    .clk            (clk),
    .reset          (reset),
    .start          (start),
    .x              (x),
    .y              (y),
    .pixel_in       (pixel_in),
    .pixel_in_valid (pixel_in_valid),
    .pix_data       (pix_data),
    .pix_valid      (pix_valid),
    .pix_ready      (pix_ready),
    .pix_eol        (pix_eol),
    .pix_eof        (pix_eof),
    .busy           (busy),
    .done           (done)
`ifdef FRAME_CHECKSUM_EN
    ,
    .checksum       (checksum)
`endif
  );

  always #5 clk = ~clk;

  // Combinational image memory, row-major
  always_comb pixel_in = mem[(int'(y) * 4 + int'(x)) % 16];

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Runs one frame; special actions trigger at the given pixel index (-1 = none)
  task automatic run_frame(input int stall_idx, input int bubble_idx,
                           input int start_idx, input int reset_idx);
    int waited;
    start = 1'b1;
    tick();
    start = 1'b0;
    check("busy_after_start", 32'(busy), 32'd1);
    check("x_after_start", 32'(x), 32'd0);
    check("y_after_start", 32'(y), 32'd0);
    for (int idx = 0; idx < 16; idx++) begin
      if (idx == bubble_idx) begin
        pixel_in_valid = 1'b0;
        for (int b = 0; b < 3; b++) begin
          tick();
          check("bubble_valid", 32'(pix_valid), 32'd0);
          check("bubble_busy", 32'(busy), 32'd1);
          check("bubble_x", 32'(x), 32'(idx % 4));
          check("bubble_y", 32'(y), 32'(idx / 4));
        end
        pixel_in_valid = 1'b1;
      end
      waited = 0;
      while (!pix_valid && waited < 20) begin
        tick();
        waited++;
      end
      check($sformatf("latency_%0d", idx), 32'(waited), 32'd1);
      if (!pix_valid) return;
      check($sformatf("data_%0d", idx), 32'(pix_data), 32'(mem[idx]));
      check($sformatf("eol_%0d", idx), 32'(pix_eol), 32'(idx % 4 == 3));
      check($sformatf("eof_%0d", idx), 32'(pix_eof), 32'(idx == 15));
      check($sformatf("x_%0d", idx), 32'(x), 32'(idx % 4));
      check($sformatf("y_%0d", idx), 32'(y), 32'(idx / 4));
      check($sformatf("done_low_%0d", idx), 32'(done), 32'd0);
      if (idx == reset_idx) begin
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_valid", 32'(pix_valid), 32'd0);
        check("rst_x", 32'(x), 32'd0);
        check("rst_y", 32'(y), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_data", 32'(pix_data), 32'd0);
        tick();
        check("rst_no_done", 32'(done), 32'd0);
        check("rst_idle", 32'(busy), 32'd0);
        return;
      end
      if (idx == stall_idx) begin
        pix_ready = 1'b0;
        for (int s = 0; s < 5; s++) begin
          tick();
          check("stall_valid", 32'(pix_valid), 32'd1);
          check("stall_data", 32'(pix_data), 32'(mem[idx]));
          check("stall_x", 32'(x), 32'(idx % 4));
          check("stall_y", 32'(y), 32'(idx / 4));
          check("stall_eol", 32'(pix_eol), 32'(idx % 4 == 3));
        end
        pix_ready = 1'b1;
      end
      if (idx == start_idx) start = 1'b1;
      tick();
      start = 1'b0;
    end
    check("done_pulse", 32'(done), 32'd1);
    check("done_busy", 32'(busy), 32'd1);
    check("done_valid", 32'(pix_valid), 32'd0);
`ifdef FRAME_CHECKSUM_EN
    check("checksum_done", 32'(checksum), 32'd1935);
`endif
    tick();
    check("done_one_cycle", 32'(done), 32'd0);
    check("idle_after_done", 32'(busy), 32'd0);
`ifdef FRAME_CHECKSUM_EN
    check("checksum_hold", 32'(checksum), 32'd1935);
`endif
    tick();
    check("no_second_done", 32'(done), 32'd0);
    check("no_restart", 32'(busy), 32'd0);
  endtask

  initial begin
    logic [7:0] pattern [16] = '{8'd0, 8'd64, 8'd128, 8'd192, 8'd32, 8'd96, 8'd160, 8'd224,
                                 8'd16, 8'd80, 8'd144, 8'd208, 8'd48, 8'd112, 8'd176, 8'd255};
    for (int i = 0; i < 16; i++) mem[i] = pattern[i];
    reset = 1'b1;
    start = 1'b0;
    pixel_in_valid = 1'b1;
    pix_ready = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_valid", 32'(pix_valid), 32'd0);
    check("reset_done", 32'(done), 32'd0);
    check("reset_x", 32'(x), 32'd0);
    check("reset_y", 32'(y), 32'd0);
    check("reset_data", 32'(pix_data), 32'd0);
    check("reset_eol", 32'(pix_eol), 32'd0);
    check("reset_eof", 32'(pix_eof), 32'd0);
`ifdef FRAME_CHECKSUM_EN
    check("reset_checksum", 32'(checksum), 32'd0);
`endif
    tick();
    check("idle_no_start", 32'(busy), 32'd0);

    run_frame(-1, -1, -1, -1);   // clean frame
    run_frame(3, -1, -1, -1);    // consumer stall on 192
    run_frame(-1, 9, -1, -1);    // memory bubble at x=1,y=2
    run_frame(-1, -1, 5, -1);    // start pulsed while holding pixel 5
    run_frame(-1, -1, -1, 6);    // reset while holding pixel 6
    run_frame(-1, -1, -1, -1);   // replay from value 0

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/image_scanner.md
IMAGE_SCANNER -- requirements
Module: image_scanner

Interface
REQ-001 The module SHALL have parameter img_height, default 4, number of image rows (1..16).
REQ-002 The module SHALL have parameter img_width, default 4, number of image columns (1..16).
REQ-003 The module SHALL have port clk, input, 1, single clock; all state updates on its rising edge.
REQ-004 The module SHALL have port reset, input, 1, synchronous active-high reset.
REQ-005 The module SHALL have port start, input, 1, frame-scan request, sampled only in IDLE.
REQ-006 The module SHALL have port x, output, 4, column address driven to the image memory.
REQ-007 The module SHALL have port y, output, 4, row address driven to the image memory.
REQ-008 The module SHALL have port pixel_in, input, 8, pixel returned combinationally by the image memory for (x,y).
REQ-009 The module SHALL have port pixel_in_valid, input, 1, qualifier for pixel_in.
REQ-010 The module SHALL have port pix_data, output, 8, streamed pixel.
REQ-011 The module SHALL have port pix_valid, output, 1, stream valid.
REQ-012 The module SHALL have port pix_ready, input, 1, downstream ready.
REQ-013 The module SHALL have port pix_eol, output, 1, high with pix_valid when the pixel is the last in its row.
REQ-014 The module SHALL have port pix_eof, output, 1, high with pix_valid when the pixel is the last in the frame.
REQ-015 The module SHALL have port busy, output, 1, high in any state other than IDLE.
REQ-016 The module SHALL have port done, output, 1, one-cycle pulse after the last pixel handshake.
REQ-017 The module SHALL have port checksum, output, 16, frame pixel sum (present only with FRAME_CHECKSUM_EN).

Function
REQ-018 The module SHALL implement FSM states IDLE, FETCH, HOLD and DONE.
REQ-019 In IDLE, start=1 SHALL set x=0 and y=0 and move the FSM to FETCH on the next edge.
REQ-020 In FETCH with pixel_in_valid=1, pix_data SHALL register pixel_in, pix_valid SHALL rise and the FSM SHALL move to HOLD; with pixel_in_valid=0 the FSM SHALL remain in FETCH with x and y held.
REQ-021 In HOLD, pix_valid, pix_data, pix_eol, pix_eof, x and y SHALL remain stable until pix_valid and pix_ready are both high on an edge.
REQ-022 On a HOLD handshake that is not the last pixel, pix_valid SHALL drop, x SHALL increment, and the FSM SHALL return to FETCH; at x=img_width-1, x SHALL wrap to 0 and y SHALL increment.
REQ-023 On the HOLD handshake at x=img_width-1 and y=img_height-1, the FSM SHALL move to DONE and pix_valid SHALL drop.
REQ-024 DONE SHALL assert done for exactly one cycle and then return to IDLE.
REQ-025 The first pix_valid SHALL appear 2 cycles after start is sampled, with pixel_in_valid=1 and no stall.
REQ-026 Sustained throughput SHALL be one pixel per 2 cycles with pix_ready held at 1.
REQ-027 start SHALL be ignored outside IDLE; start held high through DONE SHALL begin a new frame only from IDLE.
REQ-028 pix_eol SHALL equal (x==img_width-1) and pix_eof SHALL equal (x==img_width-1 && y==img_height-1), both gated by pix_valid.

Reset
REQ-029 reset=1 SHALL force, on the next edge, state=IDLE, x=0, y=0, pix_data=0, pix_valid=0, pix_eol=0, pix_eof=0, busy=0, done=0 and checksum=0, including mid-frame, where the frame is abandoned without done.

Configuration
REQ-030 With macro FRAME_CHECKSUM_EN defined, checksum SHALL clear on start accepted in IDLE, add the zero-extended pix_data modulo 2^16 on each handshake, and hold its value from DONE until the next start.
REQ-031 Without FRAME_CHECKSUM_EN, the checksum port and its accumulator SHALL be absent, and all other behaviour SHALL be identical.

Verification
REQ-032 Memory pattern 0,64,128,192,32,96,160,224,16,80,144,208,48,112,176,255 with pix_ready=1, start pulse -> 16 pixels in that order, pix_eol on pixels 192,224,208,255, pix_eof only on 255, done one cycle after the last handshake.
REQ-033 Same frame with FRAME_CHECKSUM_EN -> checksum=1935 after done.
REQ-034 pix_ready held 0 for 5 cycles on pixel 3 (value 192) -> pix_data=192 and x=3,y=0 stable for all 5 cycles, then the stream resumes with 32.
REQ-035 pixel_in_valid=0 for 3 cycles during FETCH of x=1,y=2 -> no pix_valid, FSM stays in FETCH, then pixel 80 is delivered.
REQ-036 reset asserted at pixel 6 -> next cycle busy=0, pix_valid=0, x=y=0, no done; a new start replays the frame from value 0.
REQ-037 start pulsed during HOLD -> ignored, frame order unchanged, exactly one done.
